// File: rtl/hwpe_stream_sink_realign_if.sv
// HWPE stream interface: valid/ready handshake carrying data plus byte strobes.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
) ();

    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    logic                    valid;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   data;
    logic [STRB_W-1:0]       strb;

    modport source (output valid, output data, output strb, input ready);
    modport sink   (input valid, input data, input strb, output ready);

endinterface

// File: rtl/hwpe_stream_sink_realign.sv
// Write-side realigner: byte-rotates an aligned stream into strobed words for an unaligned TCDM store.
// Optional build macro HWPE_STREAM_SINK_REALIGN_CG_EN clocks state/cnt/data_q through cluster_clock_gating.
module hwpe_stream_sink_realign #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OFF_W      = $clog2(DATA_WIDTH / 8)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 test_mode_i,
    input  logic                 clear_i,
    input  logic                 enable_i,
    input  logic                 realign_i,
    input  logic [OFF_W-1:0]     offset_i,
    input  logic [15:0]          line_length_i,
    output logic                 busy_o,
    output logic                 done_o,
    hwpe_stream_intf_stream.sink   stream_i,
    hwpe_stream_intf_stream.source stream_o
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned SH_W   = $clog2(DATA_WIDTH) + 1;
    localparam int unsigned CNT_W  = 16;

    localparam logic [STRB_W-1:0] ONES = '1;

    localparam logic [0:0] ST_STREAM = 1'b0;
    localparam logic [0:0] ST_FLUSH  = 1'b1;

    logic [0:0]            r_state;
    logic [0:0]            w_state_n;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_n;
    logic [DATA_WIDTH-1:0] r_data_q;
    logic [DATA_WIDTH-1:0] w_data_q_n;
    logic                  r_done;
    logic                  w_done_n;

    logic                  w_realign;
    logic                  w_active;
    logic                  w_last;
    logic                  w_hs_in;
    logic                  w_hs_out;
    logic [SH_W-1:0]       w_lo_shift;
    logic [SH_W-1:0]       w_hi_shift;
    logic [DATA_WIDTH-1:0] w_data_head;
    logic [DATA_WIDTH-1:0] w_data_carry;
    logic [STRB_W-1:0]     w_strb_head;
    logic                  w_clk_regs;
    logic                  w_unused_inputs;

    // Input strobes are meaningless on an aligned engine stream.
    assign w_unused_inputs = ^{stream_i.strb, test_mode_i};

    assign w_realign  = realign_i && (offset_i != '0);
    assign w_active   = enable_i && (line_length_i != '0);
    assign w_last     = (r_cnt == (line_length_i - 16'd1));
    assign w_hs_in    = stream_i.valid && stream_i.ready;
    assign w_hs_out   = stream_o.valid && stream_o.ready;

    assign w_lo_shift   = SH_W'(offset_i) << 3;
    assign w_hi_shift   = SH_W'(DATA_WIDTH) - w_lo_shift;
    assign w_data_head  = stream_i.data << w_lo_shift;
    assign w_data_carry = r_data_q >> w_hi_shift;
    assign w_strb_head  = ONES << offset_i;

    assign busy_o = (r_cnt != '0) || (r_state == ST_FLUSH);
    assign done_o = r_done;

    // Output word and handshake routing; zero-latency in STREAM.
    always_comb begin
        stream_o.valid = 1'b0;
        stream_o.data  = '0;
        stream_o.strb  = '0;
        stream_i.ready = 1'b0;
        if (w_active) begin
            if (r_state == ST_FLUSH) begin
                stream_o.valid = 1'b1;
                stream_o.data  = w_data_carry;
                stream_o.strb  = ~w_strb_head;
            end else begin
                stream_o.valid = stream_i.valid;
                stream_i.ready = stream_o.ready;
                if (!w_realign) begin
                    stream_o.data = stream_i.data;
                    stream_o.strb = ONES;
                end else if (r_cnt == '0) begin
                    stream_o.data = w_data_head;
                    stream_o.strb = w_strb_head;
                end else begin
                    stream_o.data = w_data_head | w_data_carry;
                    stream_o.strb = ONES;
                end
            end
        end
    end

    // Next-state: clear wins, enable_i qualifies every update.
    always_comb begin
        w_state_n  = r_state;
        w_cnt_n    = r_cnt;
        w_data_q_n = r_data_q;
        w_done_n   = 1'b0;
        if (clear_i) begin
            w_state_n  = ST_STREAM;
            w_cnt_n    = '0;
            w_data_q_n = '0;
        end else if (enable_i) begin
            if (r_state == ST_STREAM) begin
                if (w_hs_in) begin
                    w_data_q_n = stream_i.data;
                    if (w_last) begin
                        w_cnt_n = '0;
                        if (w_realign) begin
                            w_state_n = ST_FLUSH;
                        end else begin
                            w_done_n = 1'b1;
                        end
                    end else begin
                        w_cnt_n = r_cnt + 16'd1;
                    end
                end
            end else if (w_hs_out) begin
                w_state_n = ST_STREAM;
                w_done_n  = 1'b1;
            end
        end
    end

`ifdef HWPE_STREAM_SINK_REALIGN_CG_EN
    cluster_clock_gating i_cg (
        .clk_i     (clk_i),
        .en_i      (enable_i | clear_i),
        .test_en_i (test_mode_i),
        .clk_o     (w_clk_regs)
    );
`else
    assign w_clk_regs = clk_i;
`endif

    always_ff @(posedge w_clk_regs or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= ST_STREAM;
            r_cnt    <= '0;
            r_data_q <= '0;
        end else begin
            r_state  <= w_state_n;
            r_cnt    <= w_cnt_n;
            r_data_q <= w_data_q_n;
        end
    end

    // done stays on the free-running clock so the pulse always self-clears.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_done_n;
        end
    end

endmodule

// File: tb/tb_hwpe_stream_sink_realign.sv
// Directed bench for hwpe_stream_sink_realign at DATA_WIDTH=32.
module tb_hwpe_stream_sink_realign;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        test_mode;
    logic        clear;
    logic        enable;
    logic        realign;
    logic [1:0]  offset;
    logic [15:0] len;
    logic        busy;
    logic        done;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) s_in  ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) s_out ();

    hwpe_stream_sink_realign #(.DATA_WIDTH(32)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .test_mode_i   (test_mode),
        .clear_i       (clear),
        .enable_i      (enable),
        .realign_i     (realign),
        .offset_i      (offset),
        .line_length_i (len),
        .busy_o        (busy),
        .done_o        (done),
        .stream_i      (s_in),
        .stream_o      (s_out)
    );

    // {out valid, out data, out strb, in ready, done, busy}
    logic [39:0] obs;
    assign obs = {s_out.valid, s_out.data, s_out.strb, s_in.ready, done, busy};

    typedef struct {
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic        clr;
        logic [39:0] exp;
    } row_t;

    function automatic row_t rw(input logic iv, input logic [31:0] id, input logic ordy,
                                input logic clr, input logic v, input logic [31:0] d,
                                input logic [3:0] s, input logic r, input logic dn,
                                input logic b);
        row_t x;
        x.iv   = iv;
        x.id   = id;
        x.ordy = ordy;
        x.clr  = clr;
        x.exp  = {v, d, s, r, dn, b};
        return x;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Line configuration must not move while a line is in progress.
    logic [18:0] last_cfg = '0;
    always @(negedge clk) begin
        if (rst_n === 1'b1 && busy === 1'b1) begin
            compared++;
            if ({realign, offset, len} !== last_cfg) begin
                $display("FAIL cfg_stable: got %h want %h", {realign, offset, len}, last_cfg);
                mismatched++;
            end
        end
        last_cfg = {realign, offset, len};
    end

    task automatic test_reset();
        rst_n = 1'b0; test_mode = 1'b0; clear = 1'b0; enable = 1'b1;
        realign = 1'b1; offset = 2'd0; len = 16'd1;
        s_in.valid = 1'b0; s_in.data = '0; s_in.strb = '0; s_out.ready = 1'b1;
        #3;
        compared++;
        if ({busy, done, s_out.valid} !== 3'b000) begin
            $display("FAIL reset_state: got %b want 000", {busy, done, s_out.valid});
            mismatched++;
        end
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
        compared++;
        if (obs !== {1'b0, 32'h0, 4'hF, 1'b1, 1'b0, 1'b0}) begin
            $display("FAIL reset_idle: got %h want %h", obs, {1'b0, 32'h0, 4'hF, 1'b1, 1'b0, 1'b0});
            mismatched++;
        end
        enable = 1'b0; s_in.valid = 1'b1; s_in.data = 32'h12345678;
        #1;
        compared++;
        if ({s_out.valid, s_in.ready} !== 2'b00) begin
            $display("FAIL enable_low: got %b want 00", {s_out.valid, s_in.ready});
            mismatched++;
        end
        enable = 1'b1; len = 16'd0;
        #1;
        compared++;
        if ({s_out.valid, s_in.ready} !== 2'b00) begin
            $display("FAIL len_zero: got %b want 00", {s_out.valid, s_in.ready});
            mismatched++;
        end
        s_in.valid = 1'b0; s_in.data = '0; len = 16'd1;
        cyc();
    endtask

    task automatic test_passthrough();
        row_t rows[$];
        realign = 1'b1; offset = 2'd0; len = 16'd3;
        rows.push_back(rw(1, 32'hA0A1A2A3, 1, 0, 1, 32'hA0A1A2A3, 4'hF, 1, 0, 0));
        rows.push_back(rw(1, 32'hB0B1B2B3, 1, 0, 1, 32'hB0B1B2B3, 4'hF, 1, 0, 1));
        rows.push_back(rw(1, 32'hC0C1C2C3, 1, 0, 1, 32'hC0C1C2C3, 4'hF, 1, 0, 1));
        rows.push_back(rw(0, 32'h0,        1, 0, 0, 32'h0,        4'hF, 1, 1, 0));
        rows.push_back(rw(0, 32'h0,        1, 0, 0, 32'h0,        4'hF, 1, 0, 0));
        foreach (rows[i]) begin
            s_in.valid = rows[i].iv; s_in.data = rows[i].id;
            s_out.ready = rows[i].ordy; clear = rows[i].clr;
            #1;
            compared++;
            if (obs !== rows[i].exp) begin
                $display("FAIL passthrough[%0d]: got %h want %h", i, obs, rows[i].exp);
                mismatched++;
            end
            cyc();
        end
        // realign_i=0 forces passthrough even with a non-zero offset
        realign = 1'b0; offset = 2'd3; len = 16'd1;
        rows.delete();
        rows.push_back(rw(1, 32'hD0D1D2D3, 1, 0, 1, 32'hD0D1D2D3, 4'hF, 1, 0, 0));
        rows.push_back(rw(0, 32'h0,        1, 0, 0, 32'h0,        4'hF, 1, 1, 0));
        foreach (rows[i]) begin
            s_in.valid = rows[i].iv; s_in.data = rows[i].id;
            s_out.ready = rows[i].ordy; clear = rows[i].clr;
            #1;
            compared++;
            if (obs !== rows[i].exp) begin
                $display("FAIL passthrough_norealign[%0d]: got %h want %h", i, obs, rows[i].exp);
                mismatched++;
            end
            cyc();
        end
    endtask

    task automatic test_offset1();
        row_t rows[$];
        realign = 1'b1; offset = 2'd1; len = 16'd2;
        rows.push_back(rw(1, 32'h44332211, 1, 0, 1, 32'h33221100, 4'hE, 1, 0, 0));
        rows.push_back(rw(1, 32'h88776655, 1, 0, 1, 32'h77665544, 4'hF, 1, 0, 1));
        rows.push_back(rw(0, 32'h0,        1, 0, 1, 32'h00000088, 4'h1, 0, 0, 1));
        rows.push_back(rw(0, 32'h0,        1, 0, 0, 32'h0,        4'hE, 1, 1, 0));
        foreach (rows[i]) begin
            s_in.valid = rows[i].iv; s_in.data = rows[i].id;
            s_out.ready = rows[i].ordy; clear = rows[i].clr;
            #1;
            compared++;
            if (obs !== rows[i].exp) begin
                $display("FAIL offset1[%0d]: got %h want %h", i, obs, rows[i].exp);
                mismatched++;
            end
            cyc();
        end
    endtask

    task automatic test_offset3();
        row_t rows[$];
        realign = 1'b1; offset = 2'd3; len = 16'd1;
        rows.push_back(rw(1, 32'hDDCCBBAA, 1, 0, 1, 32'hAA000000, 4'h8, 1, 0, 0));
        rows.push_back(rw(0, 32'h0,        1, 0, 1, 32'h00DDCCBB, 4'h7, 0, 0, 1));
        rows.push_back(rw(0, 32'h0,        1, 0, 0, 32'h0,        4'h8, 1, 1, 0));
        foreach (rows[i]) begin
            s_in.valid = rows[i].iv; s_in.data = rows[i].id;
            s_out.ready = rows[i].ordy; clear = rows[i].clr;
            #1;
            compared++;
            if (obs !== rows[i].exp) begin
                $display("FAIL offset3[%0d]: got %h want %h", i, obs, rows[i].exp);
                mismatched++;
            end
            cyc();
        end
    endtask

    task automatic test_backpressure();
        row_t rows[$];
        realign = 1'b1; offset = 2'd1; len = 16'd2;
        rows.push_back(rw(1, 32'h44332211, 1, 0, 1, 32'h33221100, 4'hE, 1, 0, 0));
        rows.push_back(rw(1, 32'h88776655, 1, 0, 1, 32'h77665544, 4'hF, 1, 0, 1));
        rows.push_back(rw(0, 32'h0,        0, 0, 1, 32'h00000088, 4'h1, 0, 0, 1));
        rows.push_back(rw(0, 32'h0,        0, 0, 1, 32'h00000088, 4'h1, 0, 0, 1));
        rows.push_back(rw(0, 32'h0,        0, 0, 1, 32'h00000088, 4'h1, 0, 0, 1));
        rows.push_back(rw(0, 32'h0,        1, 0, 1, 32'h00000088, 4'h1, 0, 0, 1));
        rows.push_back(rw(0, 32'h0,        1, 0, 0, 32'h0,        4'hE, 1, 1, 0));
        rows.push_back(rw(0, 32'h0,        1, 0, 0, 32'h0,        4'hE, 1, 0, 0));
        foreach (rows[i]) begin
            s_in.valid = rows[i].iv; s_in.data = rows[i].id;
            s_out.ready = rows[i].ordy; clear = rows[i].clr;
            #1;
            compared++;
            if (obs !== rows[i].exp) begin
                $display("FAIL backpressure[%0d]: got %h want %h", i, obs, rows[i].exp);
                mismatched++;
            end
            cyc();
        end
    endtask

    task automatic test_clear();
        row_t rows[$];
        realign = 1'b1; offset = 2'd2; len = 16'd4;
        rows.push_back(rw(1, 32'h44332211, 1, 0, 1, 32'h22110000, 4'hC, 1, 0, 0));
        rows.push_back(rw(0, 32'h0,        1, 1, 0, 32'h00004433, 4'hF, 1, 0, 1));
        rows.push_back(rw(0, 32'h0,        1, 0, 0, 32'h0,        4'hC, 1, 0, 0));
        rows.push_back(rw(1, 32'h55667788, 1, 0, 1, 32'h77880000, 4'hC, 1, 0, 0));
        rows.push_back(rw(1, 32'h11223344, 1, 0, 1, 32'h33445566, 4'hF, 1, 0, 1));
        rows.push_back(rw(1, 32'hAABBCCDD, 1, 0, 1, 32'hCCDD1122, 4'hF, 1, 0, 1));
        rows.push_back(rw(1, 32'h01020304, 1, 0, 1, 32'h0304AABB, 4'hF, 1, 0, 1));
        rows.push_back(rw(0, 32'h0,        1, 0, 1, 32'h00000102, 4'h3, 0, 0, 1));
        rows.push_back(rw(0, 32'h0,        1, 0, 0, 32'h0,        4'hC, 1, 1, 0));
        foreach (rows[i]) begin
            s_in.valid = rows[i].iv; s_in.data = rows[i].id;
            s_out.ready = rows[i].ordy; clear = rows[i].clr;
            #1;
            compared++;
            if (obs !== rows[i].exp) begin
                $display("FAIL clear[%0d]: got %h want %h", i, obs, rows[i].exp);
                mismatched++;
            end
            cyc();
        end
        clear = 1'b0;
    endtask

    task automatic test_back_to_back();
        row_t rows[$];
        int   hs_out    = 0;
        int   dones     = 0;
        int   idle_in   = 0;
        realign = 1'b1; offset = 2'd2; len = 16'd2;
        rows.push_back(rw(1, 32'hA1A2A3A4, 1, 0, 1, 32'hA3A40000, 4'hC, 1, 0, 0));
        rows.push_back(rw(1, 32'hB1B2B3B4, 1, 0, 1, 32'hB3B4A1A2, 4'hF, 1, 0, 1));
        rows.push_back(rw(1, 32'hC1C2C3C4, 1, 0, 1, 32'h0000B1B2, 4'h3, 0, 0, 1));
        rows.push_back(rw(1, 32'hC1C2C3C4, 1, 0, 1, 32'hC3C40000, 4'hC, 1, 1, 0));
        rows.push_back(rw(1, 32'hD1D2D3D4, 1, 0, 1, 32'hD3D4C1C2, 4'hF, 1, 0, 1));
        rows.push_back(rw(0, 32'h0,        1, 0, 1, 32'h0000D1D2, 4'h3, 0, 0, 1));
        rows.push_back(rw(0, 32'h0,        1, 0, 0, 32'h0,        4'hC, 1, 1, 0));
        foreach (rows[i]) begin
            s_in.valid = rows[i].iv; s_in.data = rows[i].id;
            s_out.ready = rows[i].ordy; clear = rows[i].clr;
            #1;
            compared++;
            if (obs !== rows[i].exp) begin
                $display("FAIL back_to_back[%0d]: got %h want %h", i, obs, rows[i].exp);
                mismatched++;
            end
            if (s_out.valid === 1'b1 && s_out.ready === 1'b1) hs_out++;
            if (done === 1'b1) dones++;
            if (s_in.valid === 1'b1 && s_in.ready !== 1'b1) idle_in++;
            cyc();
        end
        compared++;
        if (hs_out != 6) begin
            $display("FAIL b2b_out_words: got %0d want 6", hs_out);
            mismatched++;
        end
        compared++;
        if (dones != 2) begin
            $display("FAIL b2b_done_pulses: got %0d want 2", dones);
            mismatched++;
        end
        compared++;
        if (idle_in != 1) begin
            $display("FAIL b2b_idle_inputs: got %0d want 1", idle_in);
            mismatched++;
        end
    endtask

    task automatic test_async_reset();
        realign = 1'b1; offset = 2'd1; len = 16'd2;
        s_in.valid = 1'b1; s_in.data = 32'h44332211; s_out.ready = 1'b1;
        cyc();
        s_in.valid = 1'b0; s_in.data = '0;
        #1;
        compared++;
        if (busy !== 1'b1) begin
            $display("FAIL areset_midline_busy: got %b want 1", busy);
            mismatched++;
        end
        rst_n = 1'b0;
        #1;
        compared++;
        if (obs !== {1'b0, 32'h0, 4'hE, 1'b1, 1'b0, 1'b0}) begin
            $display("FAIL areset_immediate: got %h want %h", obs, {1'b0, 32'h0, 4'hE, 1'b1, 1'b0, 1'b0});
            mismatched++;
        end
        cyc();
        rst_n = 1'b1;
        cyc();
        s_in.valid = 1'b1; s_in.data = 32'h88776655;
        #1;
        compared++;
        if (obs !== {1'b1, 32'h77665500, 4'hE, 1'b1, 1'b0, 1'b0}) begin
            $display("FAIL areset_restart: got %h want %h", obs, {1'b1, 32'h77665500, 4'hE, 1'b1, 1'b0, 1'b0});
            mismatched++;
        end
        s_in.valid = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_offset1();
        test_offset3();
        test_backpressure();
        test_clear();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/hwpe_stream_sink_realign.md
# hwpe_stream_sink_realign

Write-side counterpart of the source realigner. It takes an aligned HWPE stream and produces a byte-rotated stream with write strobes, so a TCDM sink can store a line at a byte address that is not word-aligned. For a line of N input words at byte offset OFF≠0 it emits N+1 output words: a partial first word, full middle words, and a partial flush word. It sits between the engine's output stream and the TCDM sink address generator.

## Interface
- DATA_WIDTH, 32: stream data width in bits; must be a multiple of 8 and ≥16.
- OFF_W (derived), $clog2(DATA_WIDTH/8): width of the offset field.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- test_mode_i  in  1  clock-gate bypass. Used only when the gating macro is defined.
- clear_i  in  1  synchronous clear. Returns all state to reset values.
- enable_i  in  1  when 0, both handshakes are blocked and state is frozen.
- realign_i  in  1  0 selects passthrough for any offset.
- offset_i  in  OFF_W  byte offset of the destination address; `addr[OFF_W-1:0]`.
- line_length_i  in  16  input words per line; 0 is reserved (no transfers accepted).
- busy_o  out  1  a line is in progress (cnt≠0 or state FLUSH).
- done_o  out  1  one-cycle pulse, registered, after the last output handshake of a line.
- stream_i  hwpe_stream_intf_stream.sink  DATA_WIDTH  aligned input. `strb` is ignored.
- stream_o  hwpe_stream_intf_stream.source  DATA_WIDTH + DATA_WIDTH/8  realigned output with data and strb.

## Operation
- Let S = 8·offset_i and ONES = all-ones strobe.
- Registers:
  - state ∈ {STREAM, FLUSH}
  - cnt[15:0]: input words accepted in the current line
  - data_q: the last accepted input word, loaded on every stream_i handshake
  - done_o
- Passthrough applies when realign_i=0 or offset_i=0:
  - stream_o.data = stream_i.data, strb = ONES.
  - valid and ready are wired straight through.
  - cnt still counts, and done_o pulses when the word with cnt=line_length_i−1 hands off.
  - FLUSH is never entered.
- STREAM, realign active:
  - stream_o.valid = stream_i.valid; stream_i.ready = stream_o.ready.
  - cnt=0: data = stream_i.data << S; strb = ONES << offset_i.
  - cnt>0: data = (stream_i.data << S) | (data_q >> (DATA_WIDTH−S)); strb = ONES.
  - On a handshake with cnt=line_length_i−1: go to FLUSH and set cnt to 0. Otherwise cnt increments.
- FLUSH:
  - stream_i.ready=0, stream_o.valid=1.
  - data = data_q >> (DATA_WIDTH−S); strb = ~(ONES << offset_i).
  - On the stream_o handshake: go to STREAM and pulse done_o.
- Width rules:
  - Shifts are computed in DATA_WIDTH bits; bits shifted out are discarded.
  - Strobe shifts are computed in DATA_WIDTH/8 bits.
- offset_i, realign_i and line_length_i must be stable while busy_o=1. The bench flags any change as an error; the RTL does not latch them.
- enable_i=0:
  - stream_i.ready=0, stream_o.valid=0, registers hold.
  - If valid is already asserted, dropping enable_i is a protocol error for downstream. Callers only drop enable_i between lines.
- line_length_i=0: stream_i.ready=0, stream_o.valid=0.

## Timing
- Reset and clear values: state=STREAM, cnt=0, data_q=0, done_o=0, busy_o=0.
- After reset, stream_o.valid is 0 until stream_i.valid=1 with enable_i=1.
- Latency:
  - STREAM-phase outputs are combinational from stream_i and data_q, so zero latency.
  - The flush word appears in the cycle after the last input handshake.
  - done_o is asserted in the cycle after the final output handshake.
- Line-to-line: the first word of the next line is accepted in the cycle after the flush handshake. Its output word uses cnt=0, so data_q from the previous line has no effect on it.
- Back-pressure in FLUSH: data and strb hold stable while ready=0, following the valid-before-ready rule.
- clear_i has priority over all updates. It aborts a line mid-stream or in FLUSH, and no flush word is emitted afterwards.
- rst_ni asserted mid-line: immediate return to reset values; outputs follow combinationally.
- line_length_i=1, offset≠0: exactly two output words.

## Configuration
- HWPE_STREAM_SINK_REALIGN_CG_EN defined:
  - state, cnt and data_q are clocked by cluster_clock_gating with en = enable_i | clear_i and test_en = test_mode_i.
  - done_o stays on clk_i.
- Not defined: all registers run on clk_i with enable_i as the update qualifier.
- Cycle-level behaviour at the ports is identical in both builds.

## Test plan
All scenarios use DATA_WIDTH=32.
- **Passthrough:** offset=0, len=3, words A,B,C → outputs A,B,C, each with strb 1111; no flush word; done_o pulses once.
- **Offset 1:** offset=1, len=2, inputs 0x44332211 then 0x88776655 → outputs 0x33221100/1110, 0x77665544/1111, 0x00000088/0001.
- **Offset 3:** offset=3, len=1, input 0xDDCCBBAA → outputs 0xAA000000/1000, then 0x00DDCCBB/0111; busy_o is 1 until the flush handshake.
- **Back-pressure:** as the offset-1 case, with stream_o.ready=0 for 3 cycles in FLUSH → 0x00000088/0001 held stable; stream_i.ready=0 throughout; done_o pulses only after the handshake.
- **Clear:** clear_i pulses after the first input word of a len=4, offset=2 line → cnt=0, busy_o=0, no flush word; a new line restarts with strb 1100.
- **Back-to-back lines:** two offset=2, len=2 lines with stream_i.valid held high → 6 output words, 0 idle input cycles apart from one per flush; done_o pulses twice.
